// File: rtl/map_ram_arbiter.sv
// Tile map RAM arbiter: the renderer always wins, the two game requesters share the
// remaining cycles round-robin. Every read has a fixed 2-cycle latency.
module map_ram_arbiter #(
  parameter int unsigned MAP_W        = 28,
  parameter int unsigned MAP_H        = 36,
  parameter int unsigned ADDR_W       = $clog2(MAP_W * MAP_H),
  parameter int unsigned DATA_W       = 2,
  parameter int unsigned STARVE_LIMIT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r_req,
  input  logic [ADDR_W-1:0]     r_addr,
  output logic                  r_rvalid,
  output logic [DATA_W-1:0]     r_rdata,
  input  logic [1:0]            g_valid,
  input  logic [1:0]            g_we,
  input  logic [2*ADDR_W-1:0]   g_addr,
  input  logic [2*DATA_W-1:0]   g_wdata,
  output logic [1:0]            g_ready,
  output logic [1:0]            g_rvalid,
  output logic [DATA_W-1:0]     g_rdata,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [1:0]            starve,
  output logic                  err_oob
);

  localparam int unsigned MapSize = MAP_W * MAP_H;
  localparam int unsigned CntW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W:0]   MapSizeW  = (ADDR_W + 1)'(MapSize);
  localparam logic [CntW-1:0]   StarveMax = CntW'(STARVE_LIMIT);

  logic [1:0]        gnt;
  logic              rr_q;
  logic              sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              sel_oob;
  logic              r_oob;

  // Pipeline stage 1 tags the access on the RAM port; stage 2 aligns with ram_rdata.
  logic              s1_r_q;
  logic [1:0]        s1_g_q;
  logic              s1_oob_q;
  logic              s2_oob_q;

  logic [CntW-1:0]   cnt_q [2];
  logic [CntW-1:0]   cnt_d [2];

  // Grant decode: renderer first, then a lone game request, then the RR pointer.
  always_comb begin
    gnt = 2'b00;
    if (!rst && !r_req) begin
      unique case (g_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign g_ready   = gnt;
  assign sel       = gnt[1];
  assign sel_addr  = sel ? g_addr[2*ADDR_W-1:ADDR_W] : g_addr[ADDR_W-1:0];
  assign sel_wdata = sel ? g_wdata[2*DATA_W-1:DATA_W] : g_wdata[DATA_W-1:0];
  assign sel_we    = sel ? g_we[1] : g_we[0];
  assign sel_oob   = {1'b0, sel_addr} >= MapSizeW;
  assign r_oob     = {1'b0, r_addr} >= MapSizeW;

  // Register the winning access onto the RAM port; idle cycles hold the address.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      s1_r_q    <= 1'b0;
      s1_g_q    <= 2'b00;
      s1_oob_q  <= 1'b0;
    end else begin
      ram_we   <= 1'b0;
      s1_r_q   <= 1'b0;
      s1_g_q   <= 2'b00;
      s1_oob_q <= 1'b0;
      if (r_req) begin
        ram_addr <= r_addr;
        s1_r_q   <= 1'b1;
        s1_oob_q <= r_oob;
      end else if (gnt != 2'b00) begin
        ram_addr  <= sel_addr;
        ram_wdata <= sel_wdata;
        ram_we    <= sel_we & ~sel_oob;
        s1_g_q    <= sel_we ? 2'b00 : gnt;
        s1_oob_q  <= sel_oob;
      end
    end
  end

  // Read-return stage, flushed by reset so in-flight reads never complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      g_rvalid <= 2'b00;
      s2_oob_q <= 1'b0;
    end else begin
      r_rvalid <= s1_r_q;
      g_rvalid <= s1_g_q;
      s2_oob_q <= s1_oob_q;
    end
  end

  // RAM data is only driven out while qualified; out-of-range reads return zero.
  assign r_rdata = (r_rvalid && !s2_oob_q) ? ram_rdata : '0;
  assign g_rdata = ((g_rvalid != 2'b00) && !s2_oob_q) ? ram_rdata : '0;

  // Round-robin pointer moves to the other requester after each game grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else if (gnt != 2'b00) begin
      rr_q <= gnt[0];
    end
  end

  // Sticky out-of-range flag for accepted game accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_oob <= 1'b0;
    end else if ((gnt != 2'b00) && sel_oob) begin
      err_oob <= 1'b1;
    end
  end

  // Wait counters: count blocked cycles, saturate, clear on grant or withdrawal.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (g_valid[i] && !gnt[i]) begin
        cnt_d[i] = (cnt_q[i] == StarveMax) ? cnt_q[i] : cnt_q[i] + CntW'(1);
      end
    end
  end

  // Counter state and sticky starve flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      starve   <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (cnt_d[i] == StarveMax) begin
          starve[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_map_ram_arbiter.sv
// Directed bench for map_ram_arbiter with a behavioural 1-cycle-latency map BRAM.
module tb_map_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_req;
  logic [9:0]  r_addr;
  logic        r_rvalid;
  logic [1:0]  r_rdata;
  logic [1:0]  g_valid;
  logic [1:0]  g_we;
  logic [19:0] g_addr;
  logic [3:0]  g_wdata;
  logic [1:0]  g_ready;
  logic [1:0]  g_rvalid;
  logic [1:0]  g_rdata;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [1:0]  ram_wdata;
  logic [1:0]  ram_rdata;
  logic [1:0]  starve;
  logic        err_oob;

  logic [1:0]  mem [1024];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  map_ram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .r_req     (r_req),
    .r_addr    (r_addr),
    .r_rvalid  (r_rvalid),
    .r_rdata   (r_rdata),
    .g_valid   (g_valid),
    .g_we      (g_we),
    .g_addr    (g_addr),
    .g_wdata   (g_wdata),
    .g_ready   (g_ready),
    .g_rvalid  (g_rvalid),
    .g_rdata   (g_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .starve    (starve),
    .err_oob   (err_oob)
  );

  // Synchronous single-port map RAM, read data one cycle after the address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 2'b00;
    mem[29]   = 2'b10;
    mem[1010] = 2'b11;
    mem[1015] = 2'b01;

    // 1: reset with both requesters pending
    rst = 1'b1; r_req = 1'b0; r_addr = '0;
    g_valid = 2'b11; g_we = 2'b00; g_addr = '0; g_wdata = '0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_g_ready", 32'(g_ready), 32'd0);
      tick();
    end
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_r_rvalid", 32'(r_rvalid), 32'd0);
    chk("rst_g_rvalid", 32'(g_rvalid), 32'd0);
    chk("rst_starve", 32'(starve), 32'd0);
    chk("rst_err_oob", 32'(err_oob), 32'd0);
    rst = 1'b0; g_valid = 2'b00;
    tick();

    // 2: renderer read of tile 29 with both game requesters asking
    r_req = 1'b1; r_addr = 10'd29; g_valid = 2'b11;
    #1;
    chk("rend_blocks_game", 32'(g_ready), 32'd0);
    tick();
    r_req = 1'b0; g_valid = 2'b00;
    #1;
    chk("rend_ram_addr", 32'(ram_addr), 32'd29);
    chk("rend_rvalid_n1", 32'(r_rvalid), 32'd0);
    tick();
    chk("rend_rvalid_n2", 32'(r_rvalid), 32'd1);
    chk("rend_rdata_n2", 32'(r_rdata), 32'd2);
    tick();
    chk("rend_rvalid_n3", 32'(r_rvalid), 32'd0);

    // 3: round-robin, req0 reads addr 7, req1 writes 2'b01 to addr 5
    g_valid = 2'b11; g_we = 2'b10;
    g_addr = {10'd5, 10'd7}; g_wdata = {2'b01, 2'b00};
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_grant", 32'(g_ready), (i % 2 == 1) ? 32'd2 : 32'd1);
      chk("rr_rvalid", 32'(g_rvalid), (i >= 2 && i % 2 == 0) ? 32'd1 : 32'd0);
      tick();
      chk("rr_ram_we", 32'(ram_we), (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_ram_addr", 32'(ram_addr), (i % 2 == 1) ? 32'd5 : 32'd7);
      if (i % 2 == 1) chk("rr_ram_wdata", 32'(ram_wdata), 32'd1);
    end
    g_valid = 2'b00;
    tick();
    tick();
    chk("rr_mem5", 32'(mem[5]), 32'd1);

    // 4: req0 writes 2'b11 to 100 then reads it back
    g_valid = 2'b01; g_we = 2'b01; g_addr = {10'd0, 10'd100}; g_wdata = 4'b0011;
    #1;
    chk("raw_wr_grant", 32'(g_ready), 32'd1);
    tick();
    g_we = 2'b00;
    #1;
    chk("raw_rd_grant", 32'(g_ready), 32'd1);
    tick();
    g_valid = 2'b00;
    #1;
    chk("raw_wr_no_rvalid", 32'(g_rvalid), 32'd0);
    tick();
    chk("raw_rd_rvalid", 32'(g_rvalid), 32'd1);
    chk("raw_rd_rdata", 32'(g_rdata), 32'd3);
    tick();

    // 5a: out-of-range write, game read and renderer read
    g_valid = 2'b01; g_we = 2'b01; g_addr = {10'd0, 10'd1010}; g_wdata = 4'b0010;
    #1;
    chk("oob_wr_grant", 32'(g_ready), 32'd1);
    tick();
    g_we = 2'b00;
    chk("oob_wr_suppressed", 32'(ram_we), 32'd0);
    chk("oob_err", 32'(err_oob), 32'd1);
    tick();
    g_valid = 2'b00; r_req = 1'b1; r_addr = 10'd1015;
    tick();
    r_req = 1'b0;
    chk("oob_g_rvalid", 32'(g_rvalid), 32'd1);
    chk("oob_g_rdata", 32'(g_rdata), 32'd0);
    tick();
    chk("oob_r_rvalid", 32'(r_rvalid), 32'd1);
    chk("oob_r_rdata", 32'(r_rdata), 32'd0);
    chk("oob_mem_untouched", 32'(mem[1010]), 32'd3);
    tick();

    // 5b: req1 blocked by the renderer until the starve limit
    r_req = 1'b1; r_addr = 10'd0; g_valid = 2'b10; g_we = 2'b00;
    for (int i = 0; i < 1023; i++) tick();
    chk("starve_before_limit", 32'(starve), 32'd0);
    chk("starve_blocked", 32'(g_ready), 32'd0);
    tick();
    chk("starve_at_limit", 32'(starve), 32'd2);
    r_req = 1'b0;
    #1;
    chk("starve_then_grant", 32'(g_ready), 32'd2);
    tick();
    g_valid = 2'b00;
    tick();
    tick();
    chk("starve_sticky", 32'(starve), 32'd2);
    chk("err_oob_sticky", 32'(err_oob), 32'd1);

    // 6: reset one cycle after a game read grant
    g_valid = 2'b01; g_we = 2'b00; g_addr = {10'd0, 10'd100};
    #1;
    chk("mid_rd_grant", 32'(g_ready), 32'd1);
    tick();
    g_valid = 2'b00; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_no_rvalid", 32'(g_rvalid), 32'd0);
    chk("mid_rst_starve", 32'(starve), 32'd0);
    chk("mid_rst_err_oob", 32'(err_oob), 32'd0);
    tick();
    chk("mid_rst_no_rvalid2", 32'(g_rvalid), 32'd0);
    g_valid = 2'b11;
    #1;
    chk("post_rst_rr", 32'(g_ready), 32'd1);
    tick();
    g_valid = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
